des_dec_key_sched: RTL and testbench

Sequential DES decryption key scheduler. It accepts a 64-bit key, applies PC-1, then emits the 16 round subkeys in decryption order (K16 first, K1 last), one per accepted handshake. The C/D halves rotate right between outputs. It sits beside the encryption key path and feeds the round pipeline's subkey input when the datapath runs in decrypt mode.

---
 rtl/des_pkg.sv | 64 ++++++
 rtl/des_rcs_half.sv | 19 +
 rtl/des_dec_key_sched.sv | 104 ++++++++++
 tb/tb_des_dec_key_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, types and permutation helpers.
// Bit order everywhere: MSB = DES bit 1.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned ROUNDS   = 16;

    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    localparam int unsigned PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Right-rotate applied when stepping from output n-1 to output n (decrypt order).
    localparam logic [1:0] RSCHED [ROUNDS] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] pc1_perm(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1[i])];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < SUBKEY_W; i++) begin
            k[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2[i])];
        end
        return k;
    endfunction

endpackage

// File: rtl/des_rcs_half.sv
// Rotates one 28-bit key half right by 0, 1 or 2 positions (no bit loss).
module des_rcs_half
    import des_pkg::*;
(
    input  half_t      i_half,
    input  logic [1:0] i_amt,
    output half_t      o_half
);

    always_comb begin
        o_half = i_half;
        case (i_amt)
            2'd1:    o_half = {i_half[0], i_half[HALF_W-1:1]};
            2'd2:    o_half = {i_half[1:0], i_half[HALF_W-1:2]};
            default: o_half = i_half;
        endcase
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// Sequential DES decryption key scheduler: emits K16..K1, one per valid/ready handshake.
// C/D start at PC-1(key) (= C16/D16) and rotate right between outputs.
module des_dec_key_sched
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                start,
    output logic                busy,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round_idx,
    output logic                done
);

    state_t          r_state;
    half_t           r_c;
    half_t           r_d;
    logic [3:0]      r_n;
    logic [3:0]      r_round_idx;
    logic            r_busy;
    logic            r_done;

    logic [3:0]      w_n_next;
    logic [1:0]      w_amt;
    logic [CD_W-1:0] w_cd_key;
    half_t           w_c_rot;
    half_t           w_d_rot;
    logic            w_gen;
    logic            w_unused_parity;

    assign w_n_next = r_n + 4'd1;
    assign w_amt    = RSCHED[w_n_next];
    assign w_cd_key = pc1_perm(key_in);
    assign w_gen    = (r_state == GEN);

    // Parity bits of the key are dropped by PC-1.
    assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};

    des_rcs_half u_rot_c (
        .i_half (r_c),
        .i_amt  (w_amt),
        .o_half (w_c_rot)
    );

    des_rcs_half u_rot_d (
        .i_half (r_d),
        .i_amt  (w_amt),
        .o_half (w_d_rot)
    );

    // Subkey depends only on registered C/D and state.
    assign subkey       = w_gen ? pc2_perm({r_c, r_d}) : '0;
    assign subkey_valid = w_gen;
    assign busy         = r_busy;
    assign round_idx    = r_round_idx;
    assign done         = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_c         <= '0;
            r_d         <= '0;
            r_n         <= '0;
            r_round_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_c         <= w_cd_key[CD_W-1:HALF_W];
                        r_d         <= w_cd_key[HALF_W-1:0];
                        r_n         <= 4'd0;
                        r_round_idx <= 4'd15;
                        r_busy      <= 1'b1;
                        r_state     <= GEN;
                    end
                end
                GEN: begin
                    if (subkey_ready) begin
                        if (r_n == 4'd15) begin
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_round_idx <= 4'd0;
                            r_state     <= IDLE;
                        end else begin
                            r_n         <= w_n_next;
                            r_c         <= w_c_rot;
                            r_d         <= w_d_rot;
                            r_round_idx <= r_round_idx - 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: reference DES encrypt schedule (modular left shifts
// on DES-numbered bit arrays), reversed, compared against every presented subkey.
module tb_des_dec_key_sched;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] ALT_KEY = 64'h0E329232EA6D0D73;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int LSHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key_in = '0;
    logic        start = 1'b0;
    logic        subkey_ready = 1'b0;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [47:0] exp_dec [16];
    logic [47:0] dut_k   [16];
    logic [47:0] first_k [16];

    des_dec_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .start        (start),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Encrypt schedule K1..K16 from cumulative left shifts, stored reversed.
    task automatic build_model(input logic [63:0] key);
        bit          kb  [1:64];
        bit          cd0 [1:56];
        bit          cdr [1:56];
        logic [47:0] k;
        int          s;
        for (int i = 1; i <= 64; i++) kb[i] = key[6'(64 - i)];
        for (int j = 1; j <= 56; j++) cd0[j] = kb[PC1_T[j-1]];
        s = 0;
        for (int r = 1; r <= 16; r++) begin
            s += LSHIFT_T[r-1];
            for (int j = 1; j <= 28; j++) begin
                cdr[j]      = cd0[((j - 1 + s) % 28) + 1];
                cdr[28 + j] = cd0[28 + ((j - 1 + s) % 28) + 1];
            end
            k = '0;
            for (int j = 1; j <= 48; j++) k[6'(48 - j)] = cdr[PC2_T[j-1]];
            exp_dec[16 - r] = k;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where done should be high.
    task automatic run_sched(input logic [63:0] key, input bit rand_ready,
                             input bit restart_mid, output int cycles);
        int          hs;
        int          cyc;
        bit          r;
        bit          stalled;
        logic [47:0] prev;
        build_model(key);
        key_in       = key;
        start        = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        hs      = 0;
        cyc     = 0;
        stalled = 1'b0;
        prev    = '0;
        while (hs < 16 && cyc < 200) begin
            check("valid", 64'(subkey_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("done_low", 64'(done), 64'd0);
            check("subkey", 64'(subkey), 64'(exp_dec[hs]));
            check("round_idx", 64'(round_idx), 64'(15 - hs));
            if (stalled) check("stall_hold", 64'(subkey), 64'(prev));
            dut_k[hs] = subkey;
            prev      = subkey;
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (restart_mid && hs == 5) begin
                start  = 1'b1;
                key_in = ALT_KEY;
            end else begin
                start = 1'b0;
            end
            subkey_ready = r;
            @(negedge clk);
            if (r) hs++;
            stalled = !r;
            cyc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b0;
        check("handshakes", 64'(hs), 64'd16);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("valid_end", 64'(subkey_valid), 64'd0);
        check("subkey_zero", 64'(subkey), 64'd0);
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        int n;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer schedule with ready held high.
        run_sched(KAT_KEY, 1'b0, 1'b0, cyc);
        check("gen_cycles", 64'(cyc), 64'd16);
        check("kat_k16", 64'(dut_k[0]), 64'h0000CB3D8B0E17F5);
        check("kat_k2", 64'(dut_k[14]), 64'h000079AED9DBC9E5);
        check("kat_k1", 64'(dut_k[15]), 64'h00001B02EFFC7072);
        for (int i = 0; i < 16; i++) first_k[i] = dut_k[i];
        @(negedge clk);

        // Random backpressure: same sequence.
        run_sched(KAT_KEY, 1'b1, 1'b0, cyc);
        for (int i = 0; i < 16; i++) check("stall_seq", 64'(dut_k[i]), 64'(first_k[i]));
        @(negedge clk);

        // Restart attempt mid-schedule is ignored, then back-to-back start on done.
        run_sched(KAT_KEY, 1'b0, 1'b1, cyc);
        run_sched(ALT_KEY, 1'b0, 1'b0, cyc);
        @(negedge clk);

        // Asynchronous reset at round_idx=8.
        key_in = KAT_KEY;
        start  = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        subkey_ready = 1'b1;
        n = 0;
        while (round_idx != 4'd8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_r8", 64'(round_idx), 64'd8);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(subkey_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_subkey", 64'(subkey), 64'd0);
        check("arst_round_idx", 64'(round_idx), 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        subkey_ready = 1'b0;
        @(negedge clk);
        run_sched(KAT_KEY, 1'b0, 1'b0, cyc);

        // Randomised keys, alternating ready modes, back-to-back.
        for (int t = 0; t < 6; t++) begin
            run_sched({$urandom, $urandom}, 1'((t % 2) == 1), 1'b0, cyc);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
